apb_master_if: RTL
==================

Name: apb_master_if

Overview:
- APB4 requester that drives the timer's APB slave port (tim_* bus) from a simple valid/ready command/response interface.
- Used by the SoC-side host logic and by the bench as the bus driver.
- Converts one command into one APB transfer: SETUP phase, then ACCESS phase with wait states.
- Returns read data and the slave error flag on a response channel.

Parameters:
- ADDR_W, 12, APB address width (matches tim_paddr).
- DATA_W, 32, APB data width; strobe width is DATA_W/8.
- TIMEOUT_CYC, 255, maximum ACCESS cycles before abort (used only with the optional feature).

Ports:
- sys_clk  input  1  clock
- sys_rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when high together with cmd_valid
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_W  transfer address
- cmd_wdata  input  DATA_W  write data
- cmd_strb  input  DATA_W/8  write byte strobes
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed
- rsp_rdata  output  DATA_W  read data; 0 for writes
- rsp_err  output  1  slave error (tim_pslverr) or timeout
- tim_psel  output  1  APB select
- tim_penable  output  1  APB enable
- tim_pwrite  output  1  APB direction
- tim_paddr  output  ADDR_W  APB address
- tim_pwdata  output  DATA_W  APB write data
- tim_pstrb  output  DATA_W/8  APB strobes
- tim_prdata  input  DATA_W  APB read data
- tim_pready  input  1  APB ready
- tim_pslverr  input  1  APB slave error

Behaviour:
- Clocking and reset: single clock sys_clk; reset sys_rst_n is asynchronous, active-low.
- Reset values:
  - state IDLE.
  - All tim_* outputs 0.
  - rsp_valid 0, rsp_rdata 0, rsp_err 0.
  - cmd_ready 1 (cmd_ready = state==IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: register write, addr, wdata and strb into the APB output regs; go to SETUP.
  - Reads force tim_pstrb=0 and tim_pwdata=0.
- SETUP: tim_psel=1, tim_penable=0; unconditionally go to ACCESS next cycle.
- ACCESS:
  - tim_psel=1, tim_penable=1.
  - Hold while tim_pready=0 (wait states are unbounded without the optional feature).
  - On tim_pready=1:
    - capture rsp_rdata = tim_prdata for reads, 0 for writes;
    - capture rsp_err = tim_pslverr;
    - drive tim_psel=0, tim_penable=0;
    - go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stable until rsp_ready=1.
  - Then rsp_valid=0; go to IDLE.
  - rsp_ready high in the same cycle rsp_valid rises completes the handshake in that cycle.
- Address, write, data and strobe outputs stay stable from SETUP through the final ACCESS cycle, and hold their last value afterwards. Only tim_psel and tim_penable return to 0.
- Latency with zero wait states:
  - accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3;
  - minimum 4 cycles per command (no pipelining; cmd_ready=0 outside IDLE).
- tim_pslverr and tim_prdata are sampled only in ACCESS with tim_pready=1; ignored otherwise.
- Reset asserted mid-transfer: immediate return to IDLE with the reset values above; the in-flight transfer is dropped and no response is issued.
- All outputs are registered except cmd_ready.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- With the macro:
  - an 8-bit-minimum counter (width clog2(TIMEOUT_CYC+1)) clears on entering ACCESS and increments each ACCESS cycle with tim_pready=0;
  - when the count reaches TIMEOUT_CYC, the transfer aborts next edge: tim_psel=0, tim_penable=0, rsp_rdata=0, rsp_err=1, go to RESP;
  - tim_pready=1 in the same cycle as the terminal count wins (normal completion).
- Without the macro: no counter; ACCESS waits indefinitely; port list unchanged.

Decomposition:
- Package apb_master_pkg holds:
  - FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3);
  - default ADDR_W/DATA_W constants;
  - TIMEOUT_CYC default.
- Single module; no sub-module. The timeout counter is inline under the macro.

Test Plan:
- Write, zero wait: cmd_write=1, addr=0x004, wdata=0xDEADBEEF, strb=0xF, pready tied 1 -> psel at cycle 1, penable at cycle 2, pwdata=0xDEADBEEF, rsp_valid at cycle 3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x010, slave holds pready=0 for 3 ACCESS cycles then returns prdata=0x12345678 -> tim_pstrb=0 throughout, paddr stable, rsp_rdata=0x12345678 at cycle 6.
- Slave error: write to addr=0xFFC with pslverr=1 alongside pready -> rsp_err=1; next command accepted only after the rsp_ready handshake.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held, cmd_ready=0, no new psel until rsp_ready=1.
- Reset mid-ACCESS: assert sys_rst_n=0 while pready=0 -> psel, penable and rsp_valid go to 0 asynchronously; cmd_ready=1 after reset release.
- APB_MASTER_TIMEOUT_EN with TIMEOUT_CYC=4, pready stuck 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0; repeat with pready=1 on the 4th cycle -> normal completion, rsp_err=0.

Source files
------------

// File: rtl/apb_master_pkg.sv
// apb_master_pkg
// Shared definitions for the APB4 requester apb_master_if:
//   - FSM state encoding
//   - default address/data widths of the timer's APB slave port
//   - default ACCESS-phase timeout (only meaningful with APB_MASTER_TIMEOUT_EN)
package apb_master_pkg;

    localparam int APB_ADDR_W      = 12;
    localparam int APB_DATA_W      = 32;
    localparam int APB_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage : apb_master_pkg

// File: rtl/apb_master_if.sv
// apb_master_if
// APB4 requester driving the timer's APB slave port (tim_* bus) from a
// valid/ready command channel; returns read data and the error flag on a
// valid/ready response channel. One command -> one APB transfer, no pipelining.
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase that
// has waited TIMEOUT_CYC cycles without tim_pready (response carries rsp_err=1).
// Without the macro ACCESS waits indefinitely; the port list is identical.
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (cmd_ready is high in IDLE)
//   cmd_write/addr/wdata/strb   command payload
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err          read data (0 for writes), slave error / timeout
//   tim_psel..tim_pstrb         APB requester outputs (registered)
//   tim_prdata/pready/pslverr   APB completer inputs
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready=1
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, psel=1 penable=1, waits for pready
// RESP   | response held on rsp_* until rsp_ready
module apb_master_if
    import apb_master_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,

    output logic                  tim_psel,
    output logic                  tim_penable,
    output logic                  tim_pwrite,
    output logic [ADDR_W-1:0]     tim_paddr,
    output logic [DATA_W-1:0]     tim_pwdata,
    output logic [DATA_W/8-1:0]   tim_pstrb,
    input  logic [DATA_W-1:0]     tim_prdata,
    input  logic                  tim_pready,
    input  logic                  tim_pslverr
);

    localparam int STRB_W = DATA_W / 8;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("apb_master_if: TIMEOUT_CYC must be at least 1");
    end

    apb_state_e          state_q,   state_d;
    logic                psel_q,    psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q,  pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,   paddr_d;
    logic [DATA_W-1:0]   pwdata_q,  pwdata_d;
    logic [STRB_W-1:0]   pstrb_q,   pstrb_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    // Counter is at least 8 bits wide even for small TIMEOUT_CYC values.
    localparam int CNT_W_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W     = (CNT_W_RAW > 8) ? CNT_W_RAW : 8;
    // The cycle whose increment would reach TIMEOUT_CYC is the terminal one:
    // with pready still low there, the transfer aborts on that edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
`endif

    assign cmd_ready = (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    // Reads never present stale write data or strobes on the bus.
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    pstrb_d   = cmd_write ? cmd_strb  : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d   = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (tim_pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : tim_prdata;
                    rsp_err_d   = tim_pslverr;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (wait_cnt_q == CNT_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign tim_psel    = psel_q;
    assign tim_penable = penable_q;
    assign tim_pwrite  = pwrite_q;
    assign tim_paddr   = paddr_q;
    assign tim_pwdata  = pwdata_q;
    assign tim_pstrb   = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

endmodule : apb_master_if
